// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: comparator verdict encoding
// and the successive-approximation search state encoding.
package calc_pkg;

    localparam int HEL_GT = 2;
    localparam int HEL_EQ = 1;
    localparam int HEL_LT = 0;

    localparam logic [2:0] HEL_GT_CODE = 3'b100;
    localparam logic [2:0] HEL_EQ_CODE = 3'b010;
    localparam logic [2:0] HEL_LT_CODE = 3'b001;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } search_state_t;

endpackage

// File: rtl/four_bit_comparator.sv
// Combinational 4-bit unsigned magnitude comparator with one-hot verdict.
// The rst pin acts as an enable: the verdict is all-zero while rst is low.
module four_bit_comparator
    import calc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       rst,
    output logic [2:0] hel
);

    always_comb begin
        hel = 3'b000;
        if (rst) begin
            hel[HEL_GT] = (a > b);
            hel[HEL_EQ] = (a == b);
            hel[HEL_LT] = (a < b);
        end
    end

endmodule

// File: rtl/sar_magnitude_search.sv
// Successive-approximation initiator: recovers the comparator's a operand one
// bit per cycle by steering trial values onto b and reading the HEL verdict.
module sar_magnitude_search
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       hel_in,
    output logic             cmp_en,
    output logic [WIDTH-1:0] trial,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

    search_state_t    state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] next_acc;
    logic             step;
    logic             finish;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        trial_d   = trial_q;
        acc_d     = acc_q;
        result_d  = result_q;
        done_d    = 1'b0;
        err_d     = err_q;
        next_acc  = acc_q;
        step      = 1'b0;
        finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SEARCH;
                    bit_idx_d = TOP_IDX;
                    trial_d   = MSB_ONE;
                    acc_d     = '0;
                    err_d     = 1'b0;
                end
            end
            S_SEARCH: begin
                case (hel_in)
                    HEL_EQ_CODE: begin
                        result_d = trial_q;
                        finish   = 1'b1;
                    end
                    HEL_GT_CODE: begin
                        next_acc = trial_q;
                        step     = 1'b1;
                    end
                    HEL_LT_CODE: begin
                        next_acc = acc_q;
                        step     = 1'b1;
                    end
                    default: begin
                        // Zero or multi-hot verdict: comparator is not trustworthy.
                        err_d    = 1'b1;
                        result_d = '0;
                        finish   = 1'b1;
                    end
                endcase

                if (step) begin
                    if (bit_idx_q == '0) begin
                        result_d = next_acc;
                        finish   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                        acc_d     = next_acc;
                        trial_d   = next_acc | (LSB_ONE << (bit_idx_q - 1'b1));
                    end
                end

                if (finish) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    trial_d   = '0;
                    acc_d     = '0;
                    bit_idx_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            trial_q   <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            trial_q   <= trial_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy   = (state_q == S_SEARCH);
    assign cmp_en = (state_q == S_SEARCH);
    assign trial  = trial_q;
    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_magnitude_search.sv
// Directed bench: the search block paired with a four_bit_comparator, with an
// optional verdict override to inject illegal comparator codes.
module tb_sar_magnitude_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a_val = 4'd0;
    logic       bypass = 1'b0;
    logic [2:0] bypass_hel = 3'b000;

    logic [2:0] hel_cmp;
    logic [2:0] hel_in;
    logic       cmp_en;
    logic [3:0] trial;
    logic [3:0] result;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    four_bit_comparator u_cmp (
        .a   (a_val),
        .b   (trial),
        .rst (cmp_en),
        .hel (hel_cmp)
    );

    assign hel_in = bypass ? bypass_hel : hel_cmp;

    sar_magnitude_search #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .hel_in (hel_in),
        .cmp_en (cmp_en),
        .trial  (trial),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a search on operand a and waits (bounded) for done.
    task automatic run_search(input logic [3:0] a, output logic [3:0] res,
                              output logic e, output int cycles, output logic seen);
        a_val = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 8) begin
            tick();
            cycles++;
            if (done) seen = 1'b1;
        end
        res = result;
        e = err;
        $display("search A=%0d result=%0d err=%0d cycles=%0d done_seen=%0d", a, res, e, cycles, seen);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmp_en, trial, result, busy, done, err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", {cmp_en, trial, result, busy, done, err}, 12'd0);
        end
        rst = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_a11();
        logic [3:0] exp_trial [4];
        exp_trial[0] = 4'd8; exp_trial[1] = 4'd12; exp_trial[2] = 4'd10; exp_trial[3] = 4'd11;
        a_val = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (trial !== exp_trial[c] || busy !== 1'b1 || cmp_en !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL a11_cycle%0d trial=%0d busy=%b cmp_en=%b done=%b want trial=%0d busy=1 cmp_en=1 done=0",
                         c + 1, trial, busy, cmp_en, done, exp_trial[c]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || result !== 4'd11 || err !== 1'b0 || busy !== 1'b0 || trial !== 4'd0 || cmp_en !== 1'b0) begin
            errors++;
            $display("FAIL a11_done done=%b result=%0d err=%b busy=%b trial=%0d cmp_en=%b want 1/11/0/0/0/0",
                     done, result, err, busy, trial, cmp_en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || result !== 4'd11) begin
            errors++;
            $display("FAIL a11_pulse done=%b result=%0d want done=0 result=11", done, result);
        end
        $display("search A=11 trials 8,12,10,11 result=%0d", result);
    endtask

    task automatic test_a8_early();
        a_val = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (trial !== 4'd8 || busy !== 1'b1) begin
            errors++;
            $display("FAIL a8_first trial=%0d busy=%b want 8/1", trial, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || result !== 4'd8 || trial !== 4'd0 || cmp_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL a8_early done=%b result=%0d trial=%0d cmp_en=%b busy=%b want 1/8/0/0/0",
                     done, result, trial, cmp_en, busy);
        end
        tick();
        $display("search A=8 early EQ result=%0d", result);
    endtask

    task automatic test_sweep();
        logic [3:0] res;
        logic e, seen;
        int cyc;
        run_search(4'd0, res, e, cyc, seen);
        checks++;
        if (!seen || res !== 4'd0 || cyc != 4) begin
            errors++;
            $display("FAIL a0_exact result=%0d cycles=%0d seen=%b want 0/4/1", res, cyc, seen);
        end
        tick();
        run_search(4'd15, res, e, cyc, seen);
        checks++;
        if (!seen || res !== 4'd15 || cyc != 4) begin
            errors++;
            $display("FAIL a15_exact result=%0d cycles=%0d seen=%b want 15/4/1", res, cyc, seen);
        end
        tick();
        for (int v = 0; v < 16; v++) begin
            run_search(4'(v), res, e, cyc, seen);
            checks++;
            if (!seen || res !== 4'(v) || e !== 1'b0 || cyc > 4 || cyc < 1) begin
                errors++;
                $display("FAIL sweep_a%0d result=%0d err=%b cycles=%0d seen=%b want result=%0d err=0 cycles 1..4",
                         v, res, e, cyc, seen, v);
            end
        end
    endtask

    task automatic test_illegal_verdict();
        logic [3:0] res;
        logic e, seen;
        int cyc;
        a_val = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bypass = 1'b1;
        bypass_hel = 3'b000;
        tick();
        bypass = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || result !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_abort done=%b err=%b result=%0d busy=%b want 1/1/0/0", done, err, result, busy);
        end
        $display("search A=5 forced hel=000 err=%b result=%0d", err, result);
        tick();
        checks++;
        if (done !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_hold done=%b err=%b want 0/1", done, err);
        end
        run_search(4'd5, res, e, cyc, seen);
        checks++;
        if (!seen || e !== 1'b0 || res !== 4'd5) begin
            errors++;
            $display("FAIL illegal_recover err=%b result=%0d seen=%b want 0/5/1", e, res, seen);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        a_val = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmp_en, trial, result, busy, done, err} !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid got=%b want=%b", {cmp_en, trial, result, busy, done, err}, 12'd0);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_nodone done=%b busy=%b want 0/0", done, busy);
        end
        $display("search A=9 aborted by rst");
    endtask

    task automatic test_start_busy();
        int cyc;
        logic seen;
        a_val = 4'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        // Trials 8 (LT), 4 (GT), 6 (EQ): done after the third edge.
        while (!seen && cyc < 8) begin
            start = (cyc == 1);
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!seen || cyc != 3 || result !== 4'd6 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_busy cycles=%0d result=%0d err=%b seen=%b want 3/6/0/1", cyc, result, err, seen);
        end
        $display("search A=6 with start during busy result=%0d cycles=%0d", result, cyc);
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_queued busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic seen;
        a_val = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || result !== 4'd3 || cyc != 4) begin
            errors++;
            $display("FAIL b2b_first result=%0d cycles=%0d seen=%b want 3/4/1", result, cyc, seen);
        end
        a_val = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || trial !== 4'd8 || done !== 1'b0 || result !== 4'd3) begin
            errors++;
            $display("FAIL b2b_restart busy=%b trial=%0d done=%b result=%0d want 1/8/0/3", busy, trial, done, result);
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || result !== 4'd12 || cyc != 2) begin
            errors++;
            $display("FAIL b2b_second result=%0d cycles=%0d seen=%b want 12/2/1", result, cyc, seen);
        end
        $display("search A=3 then A=12 back-to-back result=%0d", result);
        tick();
    endtask

    initial begin
        test_reset();
        test_a11();
        test_a8_early();
        test_sweep();
        test_illegal_verdict();
        test_rst_mid();
        test_start_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_magnitude_search.md
Name: sar_magnitude_search

Overview:
- Sequential initiator for the 4-bit magnitude comparator (four_bit_comparator).
- Recovers an unknown operand A, wired to the comparator's a input, by successive approximation.
- Each cycle it drives a trial value to the comparator's b input and reads back the one-hot HEL verdict.
- Lets the calculator datapath read a comparator-side operand using only the comparator's flag interface.

Parameters:
- WIDTH, 4, operand width in bits; must match the comparator width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a search; sampled only in IDLE.
- hel_in  input  3  comparator verdict for A vs trial: [2]=A>trial, [1]=A==trial, [0]=A<trial.
- cmp_en  output  1  drives the comparator's enable (its rst pin); high only while searching.
- trial  output  WIDTH  value driven to the comparator's b input.
- result  output  WIDTH  recovered A; held until the next start.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when result (and err) are valid.
- err  output  1  high with done when the search aborted on an illegal verdict; cleared on next start.

Behaviour:
- Reset value of every output: 0 (cmp_en, trial, result, busy, done, err); state=IDLE, bit_idx=0.
- All arithmetic is unsigned WIDTH-bit. Signed interpretation belongs to the caller.
- FSM states: IDLE and SEARCH. done is registered and is not a separate state.
- IDLE: when start=1 at an edge, go to SEARCH with:
  - bit_idx=WIDTH-1, trial=1<<(WIDTH-1), acc=0, err=0;
  - busy=1, cmp_en=1.
  - result is not cleared.
- SEARCH: the comparator is combinational, so hel_in reflects the registered trial within the same cycle. Each edge samples hel_in once:
  - 3'b010 (equal): result<=trial, done=1, go IDLE (early termination).
  - 3'b100 (A>trial): bit kept, next_acc=trial.
  - 3'b001 (A<trial): bit cleared, next_acc=acc.
  - Any other code, including 000 and multi-hot: err=1, result=0, done=1, go IDLE.
- After a keep or clear:
  - if bit_idx==0: result<=next_acc, done=1, go IDLE;
  - else: bit_idx<=bit_idx-1, acc<=next_acc, trial<=next_acc | (1<<(bit_idx-1)).
- Latency:
  - done asserts at most WIDTH cycles after the start-accepting edge, as an exact one-cycle pulse;
  - minimum 1 cycle, when A equals the MSB-only trial.
- On leaving SEARCH (same edge as done): busy=0, cmp_en=0, trial=0.
- start while busy: ignored, with no restart and no queueing.
- start in the same cycle done is high: state is already IDLE, so it is accepted at that edge (back-to-back searches allowed).
- rst mid-search: next edge returns all outputs and state to reset values; no done pulse.
- hel_in is ignored in IDLE.

Decomposition:
- Shared package (calc_pkg):
  - HEL bit-index constants HEL_GT=2, HEL_EQ=1, HEL_LT=0;
  - legal verdict codes HEL_GT_CODE=3'b100, HEL_EQ_CODE=3'b010, HEL_LT_CODE=3'b001;
  - state encoding S_IDLE, S_SEARCH.
- No sub-module inside the block. The top-level and the bench pair it with one four_bit_comparator instance (a=A, b=trial, rst=cmp_en, HEL=hel_in).

Test Plan:
- A=4'd11, pulse start: trials 8,12,10,11 on consecutive cycles → done at cycle 4, result=11, err=0, busy high cycles 1-4.
- A=4'd8: first trial 8 gives EQ → done 1 cycle after start, result=8, trial=0 and cmp_en=0 on the next cycle.
- A=0 and A=15: results 0 and 15 in exactly 4 cycles (A=15 ends on the EQ at trial 15); sweep all 16 values of A, each returning result==A within ≤4 cycles.
- Force hel_in=3'b000 on cycle 2 of a search (comparator bypassed) → done=1, err=1, result=0. A following start on A=5 → err=0, result=5.
- Assert rst at cycle 2 of a search on A=9 → next cycle all outputs 0 with no done. Pulse start during busy on A=6 → ignored, original search result unaffected.
- Start asserted on the done cycle of A=3 with A changed to 12 → second search begins immediately, result=12 after ≤4 cycles.
